// File: rtl/data_memory_responder.sv
// Data-memory responder: RISC-V B/H/W loads and stores on a single-port word array.
// Define STORE_BUFFER_EN to post stores into a forwarding store buffer that drains on idle cycles.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int SB_DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_write_data,
  input  logic        data_mem_read_enable,
  input  logic        data_mem_write_enable,
  input  logic [2:0]  data_mem_format,
  output logic [31:0] data_mem_read_data,
  output logic        misaligned,
  output logic        store_buffer_full,
  output logic        store_buffer_empty
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [AW-1:0] word_idx_s;
  logic [1:0]    byte_off_s;
  logic          req_s;
  logic          fmt_bad_s;
  logic          store_ok_s;
  logic          load_ok_s;
  logic [3:0]    st_mask_s;
  logic [31:0]   st_data_s;
  logic [31:0]   ld_word_s;
  logic [31:0]   ld_ext_s;
  logic [7:0]    ld_byte_s;
  logic [15:0]   ld_half_s;

  logic          mem_we_s;
  logic [AW-1:0] mem_widx_s;
  logic [3:0]    mem_wmask_s;
  logic [31:0]   mem_wdata_s;
  logic [31:0]   mem_r [DEPTH_WORDS];

  // Upper address bits only alias the array, so they are deliberately dropped.
  logic unused_addr_s;
  assign unused_addr_s = ^data_mem_address[31:AW+2];

  // Request decode and alignment / format legality.
  always_comb begin
    word_idx_s = data_mem_address[AW+1:2];
    byte_off_s = data_mem_address[1:0];
    req_s      = data_mem_read_enable | data_mem_write_enable;
    fmt_bad_s  = 1'b0;
    case (data_mem_format)
      3'b000, 3'b100: fmt_bad_s = 1'b0;
      3'b001, 3'b101: fmt_bad_s = byte_off_s[0];
      3'b010:         fmt_bad_s = (byte_off_s != 2'b00);
      default:        fmt_bad_s = 1'b1;
    endcase
    store_ok_s = data_mem_write_enable & ~fmt_bad_s;
    load_ok_s  = data_mem_read_enable & ~data_mem_write_enable & ~fmt_bad_s;
  end

  assign misaligned = req_s & fmt_bad_s;

  // Position right-aligned store data onto its byte lanes.
  always_comb begin
    st_mask_s = 4'b0000;
    st_data_s = 32'h0000_0000;
    case (data_mem_format[1:0])
      2'b00: begin
        st_mask_s = 4'b0001 << byte_off_s;
        st_data_s = {4{data_mem_write_data[7:0]}};
      end
      2'b01: begin
        st_mask_s = byte_off_s[1] ? 4'b1100 : 4'b0011;
        st_data_s = {2{data_mem_write_data[15:0]}};
      end
      2'b10: begin
        st_mask_s = 4'b1111;
        st_data_s = data_mem_write_data;
      end
      default: begin
        st_mask_s = 4'b0000;
        st_data_s = 32'h0000_0000;
      end
    endcase
  end

  // Single write port of the backing array; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask_s[b]) begin
          mem_r[mem_widx_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
        end
      end
    end
  end

`ifdef STORE_BUFFER_EN
  localparam int             SBW     = $clog2(SB_DEPTH);
  localparam logic [SBW:0]   SB_FULL = (SBW+1)'(SB_DEPTH);
  localparam logic [SBW:0]   CNT_ONE = (SBW+1)'(1);
  localparam logic [SBW-1:0] PTR_ONE = SBW'(1);

  logic [AW-1:0]  sb_idx_r  [SB_DEPTH];
  logic [3:0]     sb_mask_r [SB_DEPTH];
  logic [31:0]    sb_data_r [SB_DEPTH];
  logic [SBW-1:0] head_r;
  logic [SBW-1:0] tail_r;
  logic [SBW:0]   count_r;
  logic [SBW:0]   count_nxt_s;
  logic           full_r;
  logic           empty_r;
  logic           enq_s;
  logic           drain_s;

  // Drain on idle cycles, or force-drain the head when a store arrives at a full buffer.
  always_comb begin
    enq_s       = store_ok_s;
    drain_s     = 1'b0;
    count_nxt_s = count_r;
    if (!req_s) begin
      drain_s = (count_r != {(SBW+1){1'b0}});
    end else if (store_ok_s && (count_r == SB_FULL)) begin
      drain_s = 1'b1;
    end else begin
      drain_s = 1'b0;
    end
    if (enq_s && !drain_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!enq_s && drain_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
    mem_we_s    = drain_s;
    mem_widx_s  = sb_idx_r[head_r];
    mem_wmask_s = sb_mask_r[head_r];
    mem_wdata_s = sb_data_r[head_r];
  end

  // Buffer pointers, occupancy and registered status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= {SBW{1'b0}};
      tail_r  <= {SBW{1'b0}};
      count_r <= {(SBW+1){1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (drain_s) head_r <= head_r + PTR_ONE;
      if (enq_s)   tail_r <= tail_r + PTR_ONE;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == SB_FULL);
      empty_r <= (count_nxt_s == {(SBW+1){1'b0}});
    end
  end

  // Entry payload; when full, the tail slot equals the head slot being drained this cycle.
  always_ff @(posedge clock) begin
    if (enq_s) begin
      sb_idx_r[tail_r]  <= word_idx_s;
      sb_mask_r[tail_r] <= st_mask_s;
      sb_data_r[tail_r] <= st_data_s;
    end
  end

  // Array word overlaid with pending entries, oldest first so the youngest wins.
  always_comb begin
    ld_word_s = mem_r[word_idx_s];
    for (int i = 0; i < SB_DEPTH; i++) begin
      for (int b = 0; b < 4; b++) begin
        ld_word_s[8*b +: 8] =
          (((SBW+1)'(i) < count_r) &&
           (sb_idx_r[head_r + SBW'(i)] == word_idx_s) &&
           sb_mask_r[head_r + SBW'(i)][b]) ?
          sb_data_r[head_r + SBW'(i)][8*b +: 8] : ld_word_s[8*b +: 8];
      end
    end
  end

  assign store_buffer_full  = full_r;
  assign store_buffer_empty = empty_r;
`else
  logic [$clog2(SB_DEPTH):0] unused_sb_depth_s;
  assign unused_sb_depth_s = '0;

  // Stores go straight into the array; loads see the array only.
  always_comb begin
    mem_we_s    = store_ok_s & reset_n;
    mem_widx_s  = word_idx_s;
    mem_wmask_s = st_mask_s;
    mem_wdata_s = st_data_s;
    ld_word_s   = mem_r[word_idx_s];
  end

  assign store_buffer_full  = 1'b0;
  assign store_buffer_empty = 1'b1;
`endif

  // Select the addressed byte/half and extend per format.
  always_comb begin
    ld_byte_s = ld_word_s[{byte_off_s, 3'b000} +: 8];
    ld_half_s = byte_off_s[1] ? ld_word_s[31:16] : ld_word_s[15:0];
    case (data_mem_format)
      3'b000:  ld_ext_s = {{24{ld_byte_s[7]}}, ld_byte_s};
      3'b100:  ld_ext_s = {24'h00_0000, ld_byte_s};
      3'b001:  ld_ext_s = {{16{ld_half_s[15]}}, ld_half_s};
      3'b101:  ld_ext_s = {16'h0000, ld_half_s};
      3'b010:  ld_ext_s = ld_word_s;
      default: ld_ext_s = 32'h0000_0000;
    endcase
  end

  assign data_mem_read_data = load_ok_s ? ld_ext_s : 32'h0000_0000;

endmodule
